cfg_frame_loader: RTL and testbench
===================================

Name: cfg_frame_loader

Overview:
Parametrised configuration-frame store for the gf180 fabric tile flow. It replaces per-bit latch cells with a clocked loader. Configuration words arrive over a valid/ready stream and are assembled into a shadow frame. Each frame is committed atomically into one of NUM_FRAMES frame registers, which drive the true and complement select bits consumed by the tile's 4:1, 8:1 and 16:1 routing muxes. Frames can be read back for verification, and an aborted or out-of-range load never disturbs live configuration.

Parameters:
FRAME_BITS, 32, bits per frame; must be a multiple of WORD_W
NUM_FRAMES, 20, number of frame registers
WORD_W, 8, width of one input word
ADDR_W, 5, frame address width; must satisfy 2**ADDR_W >= NUM_FRAMES

Ports:
CLK  in  1  single clock
RST  in  1  asynchronous active-high reset
cmd_valid  in  1  load command present
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_W  target frame, sampled on cmd handshake
in_valid  in  1  data word present
in_ready  out  1  high only in LOAD
in_data  in  WORD_W  configuration word
abort  in  1  cancel the load in progress
rd_req  in  1  readback request
rd_addr  in  ADDR_W  readback frame
rd_data  out  FRAME_BITS  readback value, registered
rd_valid  out  1  rd_data valid strobe
cfg_bits  out  NUM_FRAMES*FRAME_BITS  live config; frame f occupies [f*FRAME_BITS +: FRAME_BITS]
cfg_bits_n  out  NUM_FRAMES*FRAME_BITS  bitwise complement of cfg_bits, feeds mux SxN pins
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse after a successful commit
err_addr  out  1  sticky: a load targeted cmd_addr >= NUM_FRAMES
err_clr  in  1  clears err_addr

Behaviour:
- Reset (async assert, released synchronously to CLK by the instantiating wrapper):
  - all frames 0, cfg_bits 0, cfg_bits_n all 1
  - shadow 0, word counter 0, state IDLE
  - rd_data 0, rd_valid 0, done 0, err_addr 0, busy 0
- WORDS = FRAME_BITS/WORD_W.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_addr, clear counter, go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word k (0-based) is written to shadow[k*WORD_W +: WORD_W]; word 0 is the LSBs.
  - Counter increments per accepted word and stalls while in_valid=0.
  - After word WORDS-1 is accepted, go to COMMIT.
- COMMIT (one cycle, in_ready=0):
  - If addr < NUM_FRAMES: frame[addr] <= shadow, and done=1 in the following cycle.
  - Otherwise: no write, err_addr <= 1, done stays 0.
  - Next state is IDLE.
- abort: in LOAD, abort=1 returns to IDLE next cycle. No write, the word on in_data is not accepted even if in_valid=1, and the shadow is discarded. abort is ignored in IDLE and COMMIT.
- Latency: cmd handshake at cycle 0 and back-to-back words at cycles 1..WORDS give COMMIT at cycle WORDS+1. New cfg_bits and done are visible at cycle WORDS+2.
- Other frames never change during a load; there are no partial-frame glitches.
- cfg_bits_n is registered alongside cfg_bits, never derived through an output inverter, so both update on the same edge.
- Readback:
  - rd_req at cycle t gives rd_data and rd_valid=1 at cycle t+1.
  - rd_addr >= NUM_FRAMES returns 0, with rd_valid still 1.
  - Allowed in any state.
  - rd_req in the COMMIT cycle for the same frame returns the pre-commit value.
- err_clr and a simultaneous error set in the same cycle: set wins.
- RST mid-load: all state is lost and every frame returns to 0.

Decomposition:
- Shared package cfg_pkg holds:
  - state enum (IDLE, LOAD, COMMIT)
  - WORDS computation function
  - default parameter constants
- One natural sub-module, cfg_frame_reg: a single FRAME_BITS register with write enable, true/complement outputs and async reset. It is instantiated NUM_FRAMES times via generate.
- The loader FSM, shadow register and readback mux live in the top module.

Test Plan:
(Bench configuration: FRAME_BITS=32, WORD_W=8, NUM_FRAMES=4, ADDR_W=3.)
1. Basic load: cmd_addr=2, then words 0x11,0x22,0x33,0x44 back-to-back -> cfg_bits[95:64]=0x44332211 and cfg_bits_n[95:64]=0xBBCCDDEE at cycle 6, done pulses once, other frames stay 0.
2. Stalls plus readback: same load with in_valid low for 3 cycles between each pair of words -> identical final frame. rd_req with rd_addr=2 -> rd_data=0x44332211 and rd_valid=1 on the next cycle.
3. Abort: cmd_addr=1, words 0xAA,0xBB, then abort -> frame 1 stays 0, done stays 0, busy=0 the next cycle. A new command is accepted immediately afterwards.
4. Bad address: cmd_addr=5 with 4 words -> no frame changes, err_addr=1, done=0. err_clr asserted in the same cycle as a second bad-address commit -> err_addr remains 1.
5. Read during commit: frame 0=0x0F0F0F0F, reload it with 0xFFFFFFFF, rd_req on frame 0 in the COMMIT cycle -> rd_data=0x0F0F0F0F. A rd_req one cycle later returns 0xFFFFFFFF.
6. Reset mid-load: RST asserted after 2 words -> cfg_bits=0, cfg_bits_n all 1, state IDLE immediately (asynchronous), cmd_ready=1 after release.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and defaults for the configuration-frame loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned DEF_FRAME_BITS = 32;
  localparam int unsigned DEF_NUM_FRAMES = 20;
  localparam int unsigned DEF_WORD_W     = 8;
  localparam int unsigned DEF_ADDR_W     = 5;

  // Number of input words that make up one frame.
  function automatic int unsigned calc_words(input int unsigned frame_bits,
                                             input int unsigned word_w);
    return frame_bits / word_w;
  endfunction

endpackage

// File: rtl/cfg_frame_reg.sv
// One configuration frame: clocked store with true and complement outputs.
module cfg_frame_reg #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_n
);

  // True and complement are both registered so they switch on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q   <= '0;
      q_n <= '1;
    end else if (we) begin
      q   <= d;
      q_n <= ~d;
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Stream-fed configuration loader: assembles a shadow frame and commits it
// atomically into one of NUM_FRAMES frame registers; supports readback.
module cfg_frame_loader
  import cfg_pkg::*;
#(
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_W-1:0]                in_data,
  input  logic                             abort,
  input  logic                             rd_req,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [FRAME_BITS-1:0]            rd_data,
  output logic                             rd_valid,
  output logic [NUM_FRAMES*FRAME_BITS-1:0] cfg_bits,
  output logic [NUM_FRAMES*FRAME_BITS-1:0] cfg_bits_n,
  output logic                             busy,
  output logic                             done,
  output logic                             err_addr,
  input  logic                             err_clr
);

  localparam int unsigned WORDS = calc_words(FRAME_BITS, WORD_W);
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FRAME_BITS-1:0]   shadow_q;
  logic [FRAME_BITS-1:0]   rd_sel;
  logic                    cmd_acc;
  logic                    word_acc;
  logic                    addr_ok;
  logic                    commit_ok;
  logic                    commit_bad;

  // Extra MSB keeps the range check correct when 2**ADDR_W == NUM_FRAMES.
  assign addr_ok    = ({1'b0, addr_q} < (ADDR_W+1)'(NUM_FRAMES));
  assign commit_ok  = (state_q == COMMIT) && addr_ok;
  assign commit_bad = (state_q == COMMIT) && !addr_ok;

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; abort blocks acceptance of the current word.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    cmd_acc   = 1'b0;
    word_acc  = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_acc = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          word_acc = 1'b1;
          if (cnt_q == CNT_W'(WORDS - 1)) state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow assembly, command address capture, done/error flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      done     <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      if (cmd_acc) begin
        addr_q   <= cmd_addr;
        cnt_q    <= '0;
        shadow_q <= '0;
      end
      if (word_acc) begin
        for (int unsigned k = 0; k < WORDS; k++) begin
          if (cnt_q == CNT_W'(k)) shadow_q[k*WORD_W +: WORD_W] <= in_data;
        end
        cnt_q <= cnt_q + CNT_W'(1);
      end
      done <= commit_ok;
      if (commit_bad)   err_addr <= 1'b1;
      else if (err_clr) err_addr <= 1'b0;
    end
  end

  // Frame registers; only the addressed frame is written, and only in COMMIT.
  for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_frame
    cfg_frame_reg #(.W(FRAME_BITS)) u_frame (
      .CLK (CLK),
      .RST (RST),
      .we  (commit_ok && (addr_q == ADDR_W'(f))),
      .d   (shadow_q),
      .q   (cfg_bits[f*FRAME_BITS +: FRAME_BITS]),
      .q_n (cfg_bits_n[f*FRAME_BITS +: FRAME_BITS])
    );
  end

  // Readback select; out-of-range addresses match no frame and read as zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned f = 0; f < NUM_FRAMES; f++) begin
      if (rd_addr == ADDR_W'(f)) rd_sel = cfg_bits[f*FRAME_BITS +: FRAME_BITS];
    end
  end

  // Registered readback port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed self-checking bench for cfg_frame_loader (4 frames of 32 bits, 8-bit words).
module tb_cfg_frame_loader;

  localparam int unsigned FB = 32;
  localparam int unsigned NF = 4;
  localparam int unsigned WW = 8;
  localparam int unsigned AW = 3;

  logic            CLK, RST;
  logic            cmd_valid, cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            in_valid, in_ready;
  logic [WW-1:0]   in_data;
  logic            abort, rd_req, rd_valid;
  logic [AW-1:0]   rd_addr;
  logic [FB-1:0]   rd_data;
  logic [NF*FB-1:0] cfg_bits, cfg_bits_n;
  logic            busy, done, err_addr, err_clr;

  int n_assert = 0;
  int n_fail   = 0;

  cfg_frame_loader #(
    .FRAME_BITS(FB),
    .NUM_FRAMES(NF),
    .WORD_W    (WW),
    .ADDR_W    (AW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .cfg_bits  (cfg_bits),
    .cfg_bits_n(cfg_bits_n),
    .busy      (busy),
    .done      (done),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_cmd(input logic [AW-1:0] a);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  function automatic logic [127:0] frames(input logic [31:0] f0, input logic [31:0] f1,
                                          input logic [31:0] f2, input logic [31:0] f3);
    return {f3, f2, f1, f0};
  endfunction

  logic [127:0] exp_cfg;

  initial begin
    RST = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; in_valid = 1'b0; in_data = '0;
    abort = 1'b0; rd_req = 1'b0; rd_addr = '0; err_clr = 1'b0;
    #2;
    chk("rst_cfg",       cfg_bits, '0);
    chk("rst_cfg_n",     cfg_bits_n, {128{1'b1}});
    chk("rst_busy",      {127'd0, busy}, '0);
    chk("rst_done",      {127'd0, done}, '0);
    chk("rst_err",       {127'd0, err_addr}, '0);
    chk("rst_rd",        {95'd0, rd_valid, rd_data}, '0);
    chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
    tick();
    RST = 1'b0;
    tick();

    // 1. basic load into frame 2
    do_cmd(3'd2);
    chk("t1_busy",      {127'd0, busy}, 128'd1);
    chk("t1_in_ready",  {126'd0, in_ready, cmd_ready}, 128'd2);
    send_word(8'h11, 0); send_word(8'h22, 0); send_word(8'h33, 0); send_word(8'h44, 0);
    chk("t1_commit_in_ready", {127'd0, in_ready}, '0);
    chk("t1_commit_cfg",      cfg_bits, '0);
    tick();
    exp_cfg = frames(32'h0, 32'h0, 32'h44332211, 32'h0);
    chk("t1_cfg",   cfg_bits, exp_cfg);
    chk("t1_cfg_n", cfg_bits_n, ~exp_cfg);
    chk("t1_done",  {127'd0, done}, 128'd1);
    tick();
    chk("t1_done_pulse", {126'd0, done, busy}, '0);

    // 2. stalled load and readback
    do_cmd(3'd2);
    send_word(8'h11, 3);
    chk("t2_stall_busy", {126'd0, busy, done}, 128'd2);
    send_word(8'h22, 3); send_word(8'h33, 3); send_word(8'h44, 0);
    tick();
    chk("t2_cfg",  cfg_bits, exp_cfg);
    chk("t2_done", {127'd0, done}, 128'd1);
    rd_req = 1'b1; rd_addr = 3'd2;
    tick();
    chk("t2_rd", {95'd0, rd_valid, rd_data}, {95'd0, 1'b1, 32'h44332211});
    rd_addr = 3'd6;
    tick();
    chk("t2_rd_oob", {95'd0, rd_valid, rd_data}, {95'd0, 1'b1, 32'h0});
    rd_req = 1'b0;
    tick();
    chk("t2_rd_idle", {127'd0, rd_valid}, '0);

    // 3. abort, then an immediate fresh load
    do_cmd(3'd1);
    send_word(8'hAA, 0); send_word(8'hBB, 0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("t3_busy",  {126'd0, busy, cmd_ready}, 128'd1);
    chk("t3_cfg",   cfg_bits, exp_cfg);
    tick();
    chk("t3_done",  {127'd0, done}, '0);
    do_cmd(3'd1);
    send_word(8'h01, 0); send_word(8'h02, 0); send_word(8'h03, 0); send_word(8'h04, 0);
    tick();
    exp_cfg = frames(32'h0, 32'h04030201, 32'h44332211, 32'h0);
    chk("t3_reload_cfg",  cfg_bits, exp_cfg);
    chk("t3_reload_done", {127'd0, done}, 128'd1);

    // 4. out-of-range address and error clear priority
    do_cmd(3'd5);
    send_word(8'h55, 0); send_word(8'h66, 0); send_word(8'h77, 0); send_word(8'h88, 0);
    tick();
    chk("t4_cfg",  cfg_bits, exp_cfg);
    chk("t4_flags", {126'd0, err_addr, done}, 128'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", {127'd0, err_addr}, '0);
    do_cmd(3'd7);
    send_word(8'h01, 0); send_word(8'h01, 0); send_word(8'h01, 0); send_word(8'h01, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_set_wins", {126'd0, err_addr, done}, 128'd2);
    chk("t4_cfg2",     cfg_bits, exp_cfg);

    // 5. readback during commit returns the pre-commit value
    do_cmd(3'd0);
    send_word(8'h0F, 0); send_word(8'h0F, 0); send_word(8'h0F, 0); send_word(8'h0F, 0);
    tick();
    chk("t5_first", cfg_bits, frames(32'h0F0F0F0F, 32'h04030201, 32'h44332211, 32'h0));
    do_cmd(3'd0);
    send_word(8'hFF, 0); send_word(8'hFF, 0); send_word(8'hFF, 0); send_word(8'hFF, 0);
    rd_req = 1'b1; rd_addr = 3'd0;
    tick();
    chk("t5_rd_commit", {95'd0, rd_valid, rd_data}, {95'd0, 1'b1, 32'h0F0F0F0F});
    tick();
    rd_req = 1'b0;
    chk("t5_rd_after", {95'd0, rd_valid, rd_data}, {95'd0, 1'b1, 32'hFFFFFFFF});
    exp_cfg = frames(32'hFFFFFFFF, 32'h04030201, 32'h44332211, 32'h0);
    chk("t5_cfg", cfg_bits, exp_cfg);

    // 6. asynchronous reset in the middle of a load
    do_cmd(3'd3);
    send_word(8'h12, 0); send_word(8'h34, 0);
    chk("t6_busy_pre", {127'd0, busy}, 128'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_cfg",   cfg_bits, '0);
    chk("t6_cfg_n", cfg_bits_n, {128{1'b1}});
    chk("t6_state", {125'd0, busy, in_ready, cmd_ready}, 128'd1);
    tick();
    RST = 1'b0;
    tick();
    chk("t6_cmd_ready", {126'd0, cmd_ready, busy}, 128'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
